wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, meaning consecutive cycles a non-empty aux FIFO may be denied before a forced aux grant (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 pipe_we  input  1  pipeline writeback request (writeback-stage write enable).
REQ-005 pipe_addr  input  4  pipeline destination register.
REQ-006 pipe_data  input  32  pipeline writeback data.
REQ-007 aux_valid  input  1  long-latency unit offers a result.
REQ-008 aux_addr  input  4  aux destination register.
REQ-009 aux_data  input  32  aux result data.
REQ-010 aux_ready  output  1  FIFO can accept; high when fifo_count<2.
REQ-011 rf_we  output  1  registered register-file write enable.
REQ-012 rf_waddr  output  4  registered register-file write address.
REQ-013 rf_wdata  output  32  registered register-file write data.
REQ-014 pipe_stall  output  1  pipeline shall hold writeback and upstream stages; high only in state FORCE_AUX.
REQ-015 fifo_count  output  2  aux FIFO occupancy, 0..2.

Function
REQ-016 Aux FIFO: 2 entries of {addr,data}, in-order; push when aux_valid && aux_ready.
REQ-017 aux_ready derives from registered fifo_count only; no combinational path from aux_valid.
REQ-018 FSM states NORMAL and FORCE_AUX; reset state NORMAL.
REQ-019 NORMAL grant: pipe_we=1 -> grant pipe; else fifo_count>0 at cycle start -> grant aux head and pop; else no grant.
REQ-020 No bypass: an entry pushed this cycle is grantable no earlier than the next cycle.
REQ-021 starve counter (4-bit): increments when in NORMAL, fifo_count>0 and aux not granted; clears on aux grant or fifo_count=0.
REQ-022 NORMAL -> FORCE_AUX when starve counter equals STARVE_MAX at a clock edge (checked after increment).
REQ-023 FORCE_AUX: pipe_stall=1; aux head granted and popped; pipe inputs ignored; next state NORMAL; starve counter cleared.
REQ-024 FORCE_AUX lasts exactly one cycle; pipeline re-presents its held request, granted in the following NORMAL cycle.
REQ-025 Latency: granted write appears on rf_we/rf_waddr/rf_wdata at the next rising edge; rf_we=0 in cycles with no grant, rf_waddr/rf_wdata hold previous values.
REQ-026 Full with simultaneous pop: aux_ready=0 at count 2, so only pop occurs; count 2->1.
REQ-027 Simultaneous push and pop at count 1: count stays 1, order preserved.
REQ-028 At most one register-file write per cycle; no address conflict detection (scoreboarding is external).
REQ-029 fifo_count never exceeds 2 nor underflows; pop never occurs when count=0.

Reset
REQ-030 rst=0 asynchronously forces: state NORMAL, fifo_count=0, FIFO entries invalidated, starve counter 0, rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0; aux_ready=1 after reset.
REQ-031 Reset mid-operation discards all buffered aux results and any pending forced grant; no write is issued for them.
REQ-032 Release of rst is synchronized internally; first grant no earlier than first clk edge after release.

Verification
REQ-033 pipe_we=1 addr=3 data=0x11 alone -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x11, pipe_stall=0.
REQ-034 FIFO empty, pipe idle, aux push addr=5 data=0xA5 -> count=1 next edge; rf_we=1 addr=5 data=0xA5 one cycle later; count back to 0.
REQ-035 Aux pushes 5 and 6 while pipe_we held high continuously -> after 4 denied cycles pipe_stall=1 for one cycle, rf write addr=5; 4 more denied cycles then addr=6 forced; order preserved.
REQ-036 Fill FIFO (count=2) -> aux_ready=0; aux_valid held with addr=9 not accepted until a pop; after pop count=1, aux_ready=1.
REQ-037 Pipe and aux write same cycle with count=1 -> pipe wins; aux write follows next idle cycle; no data loss.
REQ-038 rst=0 asserted with count=2 and state FORCE_AUX -> immediately rf_we=0, pipe_stall=0, count=0; after release no aux writes issued.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback normally wins, and a
// 2-entry aux FIFO drains in idle cycles or through a one-cycle forced grant.
module wb_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [3:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        aux_valid,
  input  logic [3:0]  aux_addr,
  input  logic [31:0] aux_data,
  output logic        aux_ready,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall,
  output logic [1:0]  fifo_count
);

  typedef enum logic {NORMAL, FORCE_AUX} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  logic [1:0]  rst_sync_q;
  logic        run;
  logic [3:0]  starve_q, starve_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, rd_ptr_q;
  logic [3:0]  fifo_addr_q [2];
  logic [31:0] fifo_data_q [2];
  logic        push, grant_pipe, grant_aux;
  logic        rf_we_q;
  logic [3:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;

  // Reset asserts asynchronously but releases on a clock edge, so grants only
  // start once the synchronized release has propagated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run = rst_sync_q[1];

  assign aux_ready = (count_q < 2'd2);
  assign push      = aux_valid && aux_ready;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    grant_pipe = 1'b0;
    grant_aux  = 1'b0;
    if (run) begin
      case (state_q)
        NORMAL: begin
          if (pipe_we)              grant_pipe = 1'b1;
          else if (count_q != 2'd0) grant_aux  = 1'b1;
          if (count_q == 2'd0 || grant_aux) starve_d = 4'd0;
          else if (starve_q != 4'hF)        starve_d = starve_q + 4'd1;
          if (starve_d == STARVE_LIM) state_d = FORCE_AUX;
        end
        FORCE_AUX: begin
          grant_aux = (count_q != 2'd0);
          starve_d  = 4'd0;
          state_d   = NORMAL;
        end
        default: state_d = NORMAL;
      endcase
    end
  end

  // Pop only ever comes from grant_aux, which requires a non-empty FIFO.
  always_comb begin
    count_d = count_q;
    case ({push, grant_aux})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= NORMAL;
      starve_q   <= 4'd0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 4'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      count_q  <= count_d;
      if (push)      wr_ptr_q <= ~wr_ptr_q;
      if (grant_aux) rd_ptr_q <= ~rd_ptr_q;
      rf_we_q <= grant_pipe || grant_aux;
      if (grant_pipe) begin
        rf_waddr_q <= pipe_addr;
        rf_wdata_q <= pipe_data;
      end else if (grant_aux) begin
        rf_waddr_q <= fifo_addr_q[rd_ptr_q];
        rf_wdata_q <= fifo_data_q[rd_ptr_q];
      end
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= aux_addr;
      fifo_data_q[wr_ptr_q] <= aux_data;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign pipe_stall = (state_q == FORCE_AUX);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [3:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        aux_valid;
  logic [3:0]  aux_addr;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic [1:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_data(aux_data),
    .aux_ready(aux_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    pipe_we = 1'b0; pipe_addr = 4'd0; pipe_data = 32'd0;
    aux_valid = 1'b0; aux_addr = 4'd0; aux_data = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (rf_waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", pipe_stall); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL reset_aux_ready got=%b exp=1", aux_ready); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_pipe_write();
    pipe_we = 1'b1; pipe_addr = 4'd3; pipe_data = 32'h11;
    @(negedge clk);
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL pipe_we got=%b exp=1", rf_we); end
    checks++; if (rf_waddr !== 4'd3) begin errors++; $display("FAIL pipe_addr got=%0d exp=3", rf_waddr); end
    checks++; if (rf_wdata !== 32'h11) begin errors++; $display("FAIL pipe_data got=%h exp=11", rf_wdata); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL pipe_stall got=%b exp=0", pipe_stall); end
    idle_inputs();
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pipe_idle_we got=%b exp=0", rf_we); end
    checks++; if (rf_waddr !== 4'd3 || rf_wdata !== 32'h11)
      begin errors++; $display("FAIL pipe_hold got=%0d/%h exp=3/11", rf_waddr, rf_wdata); end
  endtask

  task automatic test_aux_write();
    aux_valid = 1'b1; aux_addr = 4'd5; aux_data = 32'hA5;
    @(negedge clk);
    checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL aux_count1 got=%0d exp=1", fifo_count); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL aux_nobypass got=%b exp=0", rf_we); end
    idle_inputs();
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd5 || rf_wdata !== 32'hA5)
      begin errors++; $display("FAIL aux_write got=%b/%0d/%h exp=1/5/a5", rf_we, rf_waddr, rf_wdata); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL aux_count0 got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_starve();
    logic       exp_stall;
    logic [3:0] exp_addr;
    pipe_we = 1'b1; pipe_addr = 4'd1; pipe_data = 32'h100;
    aux_valid = 1'b1; aux_addr = 4'd5; aux_data = 32'h55;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 1) begin aux_addr = 4'd6; aux_data = 32'h66; end
      if (i == 2) begin
        aux_valid = 1'b0;
        checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL starve_count2 got=%0d exp=2", fifo_count); end
      end
      exp_stall = (i == 5 || i == 10);
      exp_addr  = (i == 6) ? 4'd5 : (i == 11) ? 4'd6 : 4'd1;
      checks++; if (pipe_stall !== exp_stall)
        begin errors++; $display("FAIL starve_stall cyc=%0d got=%b exp=%b", i, pipe_stall, exp_stall); end
      checks++; if (rf_we !== 1'b1 || rf_waddr !== exp_addr)
        begin errors++; $display("FAIL starve_write cyc=%0d got=%b/%0d exp=1/%0d", i, rf_we, rf_waddr, exp_addr); end
    end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL starve_drained got=%0d exp=0", fifo_count); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_full();
    pipe_we = 1'b1; pipe_addr = 4'd2; pipe_data = 32'h2;
    aux_valid = 1'b1; aux_addr = 4'd7; aux_data = 32'h77;
    @(negedge clk);
    aux_addr = 4'd8; aux_data = 32'h88;
    @(negedge clk);
    checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL full_count got=%0d exp=2", fifo_count); end
    checks++; if (aux_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", aux_ready); end
    pipe_we = 1'b0; aux_addr = 4'd9; aux_data = 32'h99;
    @(negedge clk);
    checks++; if (fifo_count !== 2'd1 || aux_ready !== 1'b1)
      begin errors++; $display("FAIL full_pop got=%0d/%b exp=1/1", fifo_count, aux_ready); end
    checks++; if (rf_waddr !== 4'd7) begin errors++; $display("FAIL full_first got=%0d exp=7", rf_waddr); end
    @(negedge clk);
    aux_valid = 1'b0;
    checks++; if (rf_waddr !== 4'd8 || fifo_count !== 2'd1)
      begin errors++; $display("FAIL full_pushpop got=%0d/%0d exp=8/1", rf_waddr, fifo_count); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd9 || rf_wdata !== 32'h99 || fifo_count !== 2'd0)
      begin errors++; $display("FAIL full_last got=%b/%0d/%h/%0d exp=1/9/99/0", rf_we, rf_waddr, rf_wdata, fifo_count); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_conflict();
    aux_valid = 1'b1; aux_addr = 4'hA; aux_data = 32'hAA;
    @(negedge clk);
    aux_valid = 1'b0; pipe_we = 1'b1; pipe_addr = 4'd2; pipe_data = 32'h22;
    @(negedge clk);
    checks++; if (rf_waddr !== 4'd2 || rf_wdata !== 32'h22 || fifo_count !== 2'd1)
      begin errors++; $display("FAIL conflict_pipe got=%0d/%h/%0d exp=2/22/1", rf_waddr, rf_wdata, fifo_count); end
    idle_inputs();
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'hA || rf_wdata !== 32'hAA || fifo_count !== 2'd0)
      begin errors++; $display("FAIL conflict_aux got=%b/%0d/%h/%0d exp=1/10/aa/0", rf_we, rf_waddr, rf_wdata, fifo_count); end
  endtask

  task automatic test_reset_mid();
    int stray;
    pipe_we = 1'b1; pipe_addr = 4'd1; pipe_data = 32'h100;
    aux_valid = 1'b1; aux_addr = 4'd5; aux_data = 32'h55;
    @(negedge clk);
    aux_addr = 4'd6; aux_data = 32'h66;
    @(negedge clk);
    aux_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pipe_stall !== 1'b1 || fifo_count !== 2'd2)
      begin errors++; $display("FAIL rstmid_setup got=%b/%0d exp=1/2", pipe_stall, fifo_count); end
    rst = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || pipe_stall !== 1'b0 || fifo_count !== 2'd0)
      begin errors++; $display("FAIL rstmid_async got=%b/%b/%0d exp=0/0/0", rf_we, pipe_stall, fifo_count); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rf_we !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_nowrite got=%0d exp=0", stray); end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_aux_write();
    test_starve();
    test_full();
    test_conflict();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
